// File: rtl/bus_xfer_ctrl.sv
// rtl/bus_xfer_ctrl.sv - register-to-register bus transfer sequencer (DRIVE/LATCH/DONE)
//
// Purpose: sequences one register-file transfer per request. The source register
// drives the shared bus (Rout), the destination register latches it (Rin), and
// the bus value is snooped into last_data. Base-address mode substitutes a zero
// for R0 via BAout instead of driving Rout[0].
//
// Ports:
//   clk         rising-edge clock
//   clr         asynchronous active-high reset
//   req_valid   transfer request present
//   req_ready   request accepted this cycle (IDLE and DONE)
//   req_src     source register index, drives the bus
//   req_dst     destination register index, loads from the bus
//   req_ba      base-address mode: source R0 reads as zero
//   bus_in      shared bus value, sampled in LATCH
//   Rout        one-hot bus-drive enables
//   Rin         one-hot load enables
//   BAout       R0 zero-gating strobe
//   xfer_done   one-cycle completion pulse
//   last_data   bus value captured in the last LATCH
//   xfer_count  completed-transfer count
//
// Optional feature: define XFER_COUNT_EN to build the 16-bit wrapping transfer
// counter; without it xfer_count is tied to zero and no counter flops exist.

module bus_xfer_ctrl (
    input  logic        clk,
    input  logic        clr,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_src,
    input  logic [3:0]  req_dst,
    input  logic        req_ba,
    input  logic [31:0] bus_in,
    output logic [15:0] Rout,
    output logic [15:0] Rin,
    output logic        BAout,
    output logic        xfer_done,
    output logic [31:0] last_data,
    output logic [15:0] xfer_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_LATCH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;

    // Request fields captured at accept and held through the transfer.
    logic [3:0]  src_q, src_d;
    logic [3:0]  dst_q, dst_d;
    logic        ba_q, ba_d;

    // Registered outputs.
    logic        req_ready_q, req_ready_d;
    logic [15:0] rout_q, rout_d;
    logic [15:0] rin_q, rin_d;
    logic        baout_q, baout_d;
    logic        xfer_done_q, xfer_done_d;
    logic [31:0] last_data_q, last_data_d;

    logic        accept;
    logic        bus_phase;

    assign accept = req_valid & req_ready_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic and request capture
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        ba_d    = ba_q;

        case (state_q)
            S_IDLE:  if (accept) state_d = S_DRIVE;
            S_DRIVE: state_d = S_LATCH;
            S_LATCH: state_d = S_DONE;
            // A request accepted in DONE starts the next transfer without an
            // IDLE bubble, giving one transfer every three cycles.
            S_DONE:  state_d = accept ? S_DRIVE : S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // accept can only be true in IDLE or DONE, so fields stay frozen
        // through DRIVE and LATCH even if the requester changes them.
        if (accept) begin
            src_d = req_src;
            dst_d = req_dst;
            ba_d  = req_ba;
        end
    end

    // ------------------------------------------------------------------
    // Output logic: outputs are decoded from the next state so that the
    // output flops line up with the state they belong to (Moore, registered).
    // ------------------------------------------------------------------
    always_comb begin
        rout_d      = 16'h0000;
        rin_d       = 16'h0000;
        baout_d     = 1'b0;
        xfer_done_d = 1'b0;
        req_ready_d = 1'b0;
        last_data_d = last_data_q;
        bus_phase   = (state_d == S_DRIVE) || (state_d == S_LATCH);

        if (bus_phase) begin
            // Base-address mode on R0 replaces the bus drive with the zero
            // strobe; for any other source the flag has no effect.
            if (ba_d && (src_d == 4'd0)) begin
                baout_d = 1'b1;
            end else begin
                rout_d = 16'h0001 << src_d;
            end
        end

        if (state_d == S_LATCH) begin
            rin_d = 16'h0001 << dst_d;
        end

        xfer_done_d = (state_d == S_DONE);
        req_ready_d = (state_d == S_IDLE) || (state_d == S_DONE);

        // Bus is sampled on the LATCH -> DONE edge.
        if (state_q == S_LATCH) begin
            last_data_d = bus_in;
        end
    end

    // ------------------------------------------------------------------
    // Field and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            src_q       <= 4'd0;
            dst_q       <= 4'd0;
            ba_q        <= 1'b0;
            req_ready_q <= 1'b1;
            rout_q      <= 16'h0000;
            rin_q       <= 16'h0000;
            baout_q     <= 1'b0;
            xfer_done_q <= 1'b0;
            last_data_q <= 32'h0000_0000;
        end else begin
            src_q       <= src_d;
            dst_q       <= dst_d;
            ba_q        <= ba_d;
            req_ready_q <= req_ready_d;
            rout_q      <= rout_d;
            rin_q       <= rin_d;
            baout_q     <= baout_d;
            xfer_done_q <= xfer_done_d;
            last_data_q <= last_data_d;
        end
    end

    assign req_ready = req_ready_q;
    assign Rout      = rout_q;
    assign Rin       = rin_q;
    assign BAout     = baout_q;
    assign xfer_done = xfer_done_q;
    assign last_data = last_data_q;

    // ------------------------------------------------------------------
    // Completed-transfer counter
    // ------------------------------------------------------------------
`ifdef XFER_COUNT_EN
    logic [15:0] xfer_count_q, xfer_count_d;

    // Counts alongside xfer_done so the new value is visible in DONE; an
    // abandoned transfer never reaches DONE and is not counted.
    always_comb begin
        xfer_count_d = xfer_count_q;
        if (state_d == S_DONE) begin
            xfer_count_d = xfer_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            xfer_count_q <= 16'h0000;
        end else begin
            xfer_count_q <= xfer_count_d;
        end
    end

    assign xfer_count = xfer_count_q;
`else
    assign xfer_count = 16'h0000;
`endif

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// tb/tb_bus_xfer_ctrl.sv - self-checking bench for bus_xfer_ctrl
module tb_bus_xfer_ctrl;

    logic        clk;
    logic        clr;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_src;
    logic [3:0]  req_dst;
    logic        req_ba;
    logic [31:0] bus_in;
    logic [15:0] Rout;
    logic [15:0] Rin;
    logic        BAout;
    logic        xfer_done;
    logic [31:0] last_data;
    logic [15:0] xfer_count;

    bus_xfer_ctrl dut (
        .clk        (clk),
        .clr        (clr),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_src    (req_src),
        .req_dst    (req_dst),
        .req_ba     (req_ba),
        .bus_in     (bus_in),
        .Rout       (Rout),
        .Rin        (Rin),
        .BAout      (BAout),
        .xfer_done  (xfer_done),
        .last_data  (last_data),
        .xfer_count (xfer_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: each accepted request becomes three phase records
    // (1 = drive, 2 = latch, 3 = done); the queue head is the current cycle.
    typedef struct {
        int         ph;
        logic [3:0] s;
        logic [3:0] d;
        logic       b;
    } phase_t;

    phase_t      mq[$];
    logic [31:0] m_last  = 32'h0;
    logic [15:0] m_count = 16'h0;

    task automatic model_clear();
        mq.delete();
        m_last  = 32'h0;
        m_count = 16'h0;
    endtask

    task automatic step(input logic v, input logic [3:0] s, input logic [3:0] d,
                        input logic b, input logic [31:0] bus);
        logic        acc;
        int          ph;
        phase_t      p;
        logic [15:0] e_rout, e_rin;
        logic        e_ba;
        req_valid = v;
        req_src   = s;
        req_dst   = d;
        req_ba    = b;
        bus_in    = bus;
        acc = v && (mq.size() == 0 || mq[0].ph == 3);
        if (mq.size() != 0 && mq[0].ph == 2) m_last = bus;
        @(posedge clk);
        if (mq.size() != 0) void'(mq.pop_front());
        if (acc) begin
            for (int k = 1; k <= 3; k++) begin
                p.ph = k; p.s = s; p.d = d; p.b = b;
                mq.push_back(p);
            end
        end
        ph = (mq.size() != 0) ? mq[0].ph : 0;
`ifdef XFER_COUNT_EN
        if (ph == 3) m_count = m_count + 16'd1;
`endif
        e_rout = 16'h0; e_rin = 16'h0; e_ba = 1'b0;
        if (ph == 1 || ph == 2) begin
            if (mq[0].b && mq[0].s == 4'd0) e_ba = 1'b1;
            else e_rout[mq[0].s] = 1'b1;
        end
        if (ph == 2) e_rin[mq[0].d] = 1'b1;
        #1;
        cyc++;
        chk("rout",       {16'h0, Rout},       {16'h0, e_rout});
        chk("rin",        {16'h0, Rin},        {16'h0, e_rin});
        chk("baout",      {31'h0, BAout},      {31'h0, e_ba});
        chk("xfer_done",  {31'h0, xfer_done},  {31'h0, (ph == 3)});
        chk("req_ready",  {31'h0, req_ready},  {31'h0, (ph == 0 || ph == 3)});
        chk("last_data",  last_data,           m_last);
        chk("xfer_count", {16'h0, xfer_count}, {16'h0, m_count});
    endtask

    // At most one bit of Rin and of Rout in every cycle.
    always @(negedge clk) begin
        if (!clr) begin
            total++;
            if ($countones(Rout) > 1 || $countones(Rin) > 1) begin
                bad++;
                $display("FAIL onehot: Rout=%h Rin=%h", Rout, Rin);
            end
        end
    end

    typedef struct {
        logic [3:0]  src;
        logic [3:0]  dst;
        logic        ba;
        logic [31:0] bus;
        logic [15:0] rout;
        logic [15:0] rin;
        logic        baout;
    } vec_t;

    vec_t vt[7];
    int   done_cycs[$];

    initial begin
        vt[0] = '{4'd3,  4'd7,  1'b0, 32'h0000_00A5, 16'h0008, 16'h0080, 1'b0};
        vt[1] = '{4'd0,  4'd5,  1'b1, 32'hDEAD_BEEF, 16'h0000, 16'h0020, 1'b1};
        vt[2] = '{4'd0,  4'd5,  1'b0, 32'h1234_5678, 16'h0001, 16'h0020, 1'b0};
        vt[3] = '{4'd12, 4'd12, 1'b0, 32'hCAFE_0001, 16'h1000, 16'h1000, 1'b0};
        vt[4] = '{4'd4,  4'd0,  1'b1, 32'h0F0F_0F0F, 16'h0010, 16'h0001, 1'b0};
        vt[5] = '{4'd15, 4'd0,  1'b0, 32'hFFFF_FFFF, 16'h8000, 16'h0001, 1'b0};
        vt[6] = '{4'd0,  4'd0,  1'b1, 32'h8000_0000, 16'h0000, 16'h0001, 1'b1};

        req_valid = 1'b0; req_src = 4'd0; req_dst = 4'd0; req_ba = 1'b0; bus_in = 32'h0;
        clr = 1'b0;
        #2 clr = 1'b1;
        #1;
        chk("rst_rout",  {16'h0, Rout},       32'h0);
        chk("rst_rin",   {16'h0, Rin},        32'h0);
        chk("rst_ba",    {31'h0, BAout},      32'h0);
        chk("rst_done",  {31'h0, xfer_done},  32'h0);
        chk("rst_last",  last_data,           32'h0);
        chk("rst_count", {16'h0, xfer_count}, 32'h0);
        chk("rst_ready", {31'h0, req_ready},  32'h1);
        @(posedge clk); @(posedge clk);
        #3 clr = 1'b0;
        model_clear();

        // Directed single transfers from the table.
        for (int i = 0; i < 7; i++) begin
            step(1'b1, vt[i].src, vt[i].dst, vt[i].ba, vt[i].bus);
            chk("tbl_drive_rout", {16'h0, Rout},  {16'h0, vt[i].rout});
            chk("tbl_drive_ba",   {31'h0, BAout}, {31'h0, vt[i].baout});
            chk("tbl_drive_rin",  {16'h0, Rin},   32'h0);
            step(1'b0, 4'd0, 4'd0, 1'b0, vt[i].bus);
            chk("tbl_latch_rout", {16'h0, Rout},  {16'h0, vt[i].rout});
            chk("tbl_latch_rin",  {16'h0, Rin},   {16'h0, vt[i].rin});
            chk("tbl_latch_ba",   {31'h0, BAout}, {31'h0, vt[i].baout});
            step(1'b0, 4'd0, 4'd0, 1'b0, vt[i].bus);
            chk("tbl_done",       {31'h0, xfer_done}, 32'h1);
            chk("tbl_last",       last_data, vt[i].bus);
            chk("tbl_done_rout",  {16'h0, Rout | Rin}, 32'h0);
            step(1'b0, 4'd0, 4'd0, 1'b0, 32'h0);
            chk("tbl_idle_ready", {31'h0, req_ready}, 32'h1);
        end

        // Back-to-back: valid held high, 1->2 then 4->6.
        done_cycs.delete();
        step(1'b1, 4'd1, 4'd2, 1'b0, 32'h11);
        if (xfer_done) done_cycs.push_back(cyc);
        step(1'b1, 4'd1, 4'd2, 1'b0, 32'h22);
        if (xfer_done) done_cycs.push_back(cyc);
        step(1'b1, 4'd4, 4'd6, 1'b0, 32'h33);
        if (xfer_done) done_cycs.push_back(cyc);
        step(1'b1, 4'd4, 4'd6, 1'b0, 32'h44);
        if (xfer_done) done_cycs.push_back(cyc);
        chk("b2b_drive_rout", {16'h0, Rout}, 32'h0010);
        step(1'b0, 4'd0, 4'd0, 1'b0, 32'h55);
        if (xfer_done) done_cycs.push_back(cyc);
        step(1'b0, 4'd0, 4'd0, 1'b0, 32'h66);
        if (xfer_done) done_cycs.push_back(cyc);
        step(1'b0, 4'd0, 4'd0, 1'b0, 32'h0);
        if (xfer_done) done_cycs.push_back(cyc);
        chk("b2b_pulses", done_cycs.size(), 32'd2);
        if (done_cycs.size() == 2) chk("b2b_spacing", done_cycs[1] - done_cycs[0], 32'd3);
        chk("b2b_last", last_data, 32'h66);

        // Asynchronous clear during LATCH of 9 -> 10.
        step(1'b1, 4'd9, 4'd10, 1'b0, 32'h99);
        step(1'b0, 4'd0, 4'd0, 1'b0, 32'h99);
        chk("clr_pre_rin", {16'h0, Rin}, 32'h0400);
        #2 clr = 1'b1;
        #1;
        chk("clr_async_rout", {16'h0, Rout},  32'h0);
        chk("clr_async_rin",  {16'h0, Rin},   32'h0);
        chk("clr_async_ba",   {31'h0, BAout}, 32'h0);
        chk("clr_async_last", last_data,      32'h0);
        clr = 1'b0;
        model_clear();
        step(1'b0, 4'd0, 4'd0, 1'b0, 32'h99);
        chk("clr_no_done",  {31'h0, xfer_done},  32'h0);
        chk("clr_ready",    {31'h0, req_ready},  32'h1);
        chk("clr_count",    {16'h0, xfer_count}, 32'h0);
        step(1'b0, 4'd0, 4'd0, 1'b0, 32'h99);
        chk("clr_no_done2", {31'h0, xfer_done},  32'h0);

        // Randomized traffic against the phase-queue model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 6), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_xfer_ctrl.md
BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock; clr  input  1  asynchronous active-high reset.
REQ-002 req_valid  input  1  transfer request present.
REQ-003 req_ready  output  1  block accepts a request this cycle.
REQ-004 req_src  input  4  source register index (R0..R15) to drive the bus.
REQ-005 req_dst  input  4  destination register index (R0..R15) to latch from the bus.
REQ-006 req_ba  input  1  base-address mode: source R0 reads as zero.
REQ-007 bus_in  input  32  shared bus value, sampled during LATCH.
REQ-008 Rout  output  16  one-hot register bus-drive enables.
REQ-009 Rin  output  16  one-hot register load enables.
REQ-010 BAout  output  1  R0 zero-gating strobe to R0 register.
REQ-011 xfer_done  output  1  one-cycle pulse on transfer completion.
REQ-012 last_data  output  32  bus value captured in the last LATCH.
REQ-013 xfer_count  output  16  completed-transfer count (see Configuration).

Function
REQ-014 The FSM SHALL have states IDLE, DRIVE, LATCH and DONE; all outputs SHALL be registered (Moore).
REQ-015 req_ready SHALL be 1 in IDLE and DONE, 0 in DRIVE and LATCH.
REQ-016 A request is accepted when req_valid & req_ready at a rising edge; req_src, req_dst and req_ba SHALL be captured then and held until DONE.
REQ-017 IDLE -> DRIVE on accept; otherwise stay in IDLE.
REQ-018 DRIVE -> LATCH unconditionally; DRIVE SHALL assert Rout[src] only, except when req_ba=1 and src=0, where BAout=1 and Rout=0.
REQ-019 LATCH -> DONE unconditionally; LATCH SHALL keep the DRIVE strobes, also assert Rin[dst], and capture bus_in into last_data at the LATCH->DONE edge.
REQ-020 DONE SHALL deassert Rout, Rin and BAout and pulse xfer_done=1 for exactly one cycle.
REQ-021 DONE -> DRIVE if a request is accepted in DONE (back-to-back, no IDLE cycle); otherwise DONE -> IDLE.
REQ-022 Minimum latency SHALL be 3 cycles from accept to xfer_done; back-to-back throughput SHALL be one transfer per 3 cycles.
REQ-023 src=dst SHALL be legal: Rout[n] and Rin[n] both high in LATCH.
REQ-024 req_ba SHALL be ignored when src != 0; dst=0 with req_ba=1 SHALL load R0 normally.
REQ-025 Rin and Rout SHALL each have at most one bit set in every cycle.
REQ-026 req_valid deasserted in DRIVE/LATCH SHALL NOT abort an accepted transfer.

Reset
REQ-027 clr=1 SHALL immediately (asynchronously) force state IDLE, Rout=0, Rin=0, BAout=0, xfer_done=0, last_data=0, xfer_count=0, captured fields=0.
REQ-028 clr asserted mid-transfer SHALL abandon it with no xfer_done and no count increment.
REQ-029 req_ready SHALL be 1 in the first cycle after clr deasserts.

Configuration
REQ-030 Macro XFER_COUNT_EN: when defined, xfer_count SHALL increment by 1 on every DONE cycle, wrapping 0xFFFF -> 0x0000.
REQ-031 Without XFER_COUNT_EN, xfer_count SHALL be constant 0 and no counter flops SHALL be inferred; all other behaviour SHALL be identical.

Verification
REQ-032 Reset then src=3, dst=7, ba=0, bus_in=0x0000_00A5 -> Rout=0x0008 in DRIVE; Rout=0x0008 and Rin=0x0080 in LATCH; xfer_done in cycle 3; last_data=0x0000_00A5.
REQ-033 src=0, dst=5, ba=1 -> BAout=1, Rout=0x0000 in DRIVE and LATCH, Rin=0x0020 in LATCH; same with ba=0 -> Rout=0x0001, BAout=0.
REQ-034 req_valid held high with src/dst 1->2 then 4->6 -> second DRIVE directly follows first DONE; two xfer_done pulses 3 cycles apart.
REQ-035 clr pulsed during LATCH of src=9, dst=10 -> Rout, Rin, BAout drop to 0 without waiting for clk; no xfer_done; xfer_count unchanged at 0; req_ready=1 next cycle.
REQ-036 XFER_COUNT_EN defined, 65537 transfers -> xfer_count=0x0001; undefined -> xfer_count=0 throughout.
REQ-037 src=dst=12 -> Rout=0x1000 and Rin=0x1000 together in LATCH only; one-hot assertion on Rin/Rout holds every cycle.
